// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Multiplies by shift-add, divides by restoring division, one bit per cycle.
module hilo_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mf_req,
  input  logic            flush,
  output logic [XLEN-1:0] hi_reg,
  output logic [XLEN-1:0] lo_reg,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [CW-1:0]     cnt_q;
  logic              is_div_q, neg_lo_q, neg_hi_q, done_q;

  logic              op_live, signed_op, op_is_div, rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, iter_next, prod;
  logic [XLEN-1:0]   res_hi, res_lo;

  always_comb begin
    op_live   = op_valid && (op != 3'd0) && (op != 3'd7);
    signed_op = (op == 3'd1) || (op == 3'd3);
    op_is_div = (op == 3'd3) || (op == 3'd4);
    rs_neg    = signed_op & rs_data[XLEN-1];
    rt_neg    = signed_op & rt_data[XLEN-1];
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;

    // Multiply: upper half accumulates, lower half holds the shrinking multiplier.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    iter_next = is_div_q ? div_next : mul_next;
    prod      = neg_lo_q ? -iter_next : iter_next;

    if (is_div_q) begin
      res_lo = neg_lo_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
      res_hi = neg_hi_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
    end else begin
      res_lo = prod[XLEN-1:0];
      res_hi = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_live && !flush) begin
            case (op)
              3'd5: hi_q <= rs_data;
              3'd6: lo_q <= rs_data;
              default: begin
                is_div_q <= op_is_div;
                acc_q    <= op_is_div ? {{XLEN{1'b0}}, rs_mag} : {{XLEN{1'b0}}, rt_mag};
                opnd_q   <= op_is_div ? rt_mag : rs_mag;
                // A zero divisor yields an all-ones quotient and the raw dividend as remainder.
                neg_lo_q <= op_is_div ? ((rs_neg ^ rt_neg) & (rt_data != '0)) : (rs_neg ^ rt_neg);
                neg_hi_q <= op_is_div ? rs_neg : (rs_neg ^ rt_neg);
                cnt_q    <= '0;
                state_q  <= S_RUN;
              end
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= iter_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign hi_reg = hi_q;
  assign lo_reg = lo_q;
  assign busy   = (state_q == S_RUN);
  assign done   = done_q;
  assign stall  = busy & (mf_req | op_live);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: arithmetic reference model compared every cycle plus directed literal checks.
module tb_hilo_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, op_valid, mf_req, flush;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] hi_reg, lo_reg;
  logic        busy, stall, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_data(rs), .rt_data(rt),
    .mf_req(mf_req), .flush(flush), .hi_reg(hi_reg), .lo_reg(lo_reg),
    .busy(busy), .stall(stall), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result as {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: ref_result = sa * sb;
      3'd2: ref_result = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 0) ref_result = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_result = {r[31:0], q[31:0]};
        end
      end
      default: ref_result = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem;
  logic        m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1;
          end
        end
      end else if (op_valid && !flush && op >= 1 && op <= 6) begin
        if (op == 5) m_hi = rs;
        else if (op == 6) m_lo = rs;
        else begin
          {p_hi, p_lo} = ref_result(op, rs, rt);
          m_rem = 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = (m_rem > 0);
    chk("cyc_hi", {32'd0, hi_reg}, {32'd0, m_hi});
    chk("cyc_lo", {32'd0, lo_reg}, {32'd0, m_lo});
    chk("cyc_busy", {63'd0, busy}, {63'd0, exp_busy});
    chk("cyc_done", {63'd0, done}, {63'd0, m_done});
    chk("cyc_stall", {63'd0, stall},
        {63'd0, exp_busy & (mf_req | (op_valid & (op >= 1) & (op <= 6)))});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1; op = o; rs = a; rt = b;
    step();
    op_valid = 0; op = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  initial begin
    int stall_cycles;
    rst = 1; op_valid = 0; op = 0; rs = 0; rt = 0; mf_req = 0; flush = 0;

    chk("model_mult",  ref_result(3'd1, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    chk("model_multu", ref_result(3'd2, 32'hFFFFFFFD, 32'd7), 64'h00000006_FFFFFFEB);
    chk("model_div",   ref_result(3'd3, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divov", ref_result(3'd3, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("model_div0",  ref_result(3'd3, 32'hFFFFFFF9, 32'd0), 64'hFFFFFFF9_FFFFFFFF);

    step(); step();
    rst = 0;
    chk("reset_hi", {32'd0, hi_reg}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);

    send(3'd5, 32'h12345678, 32'd0);
    chk("mthi", {32'd0, hi_reg}, 64'h12345678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    send(3'd6, 32'h9ABCDEF0, 32'd0);
    chk("mtlo", {32'd0, lo_reg}, 64'h9ABCDEF0);

    send(3'd1, 32'hFFFFFFFD, 32'd7);
    op_valid = 1; op = 3'd7;
    repeat (3) step();
    op = 3'd5; rs = 32'hDEADBEEF;
    repeat (3) step();
    chk("hold_hi", {32'd0, hi_reg}, 64'h12345678);
    op_valid = 0; op = 0;
    wait_idle();
    chk("mult", {hi_reg, lo_reg}, 64'hFFFFFFFF_FFFFFFEB);

    send(3'd2, 32'hFFFFFFFD, 32'd7);
    wait_idle();
    chk("multu", {hi_reg, lo_reg}, 64'h00000006_FFFFFFEB);

    send(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    chk("div", {hi_reg, lo_reg}, 64'hFFFFFFFF_FFFFFFFD);

    send(3'd4, 32'd100, 32'd0);
    wait_idle();
    chk("divu_zero", {hi_reg, lo_reg}, 64'h00000064_FFFFFFFF);

    send(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk("div_ovf", {hi_reg, lo_reg}, 64'h00000000_80000000);

    mf_req = 1;
    send(3'd4, 32'd1000, 32'd3);
    stall_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (stall) stall_cycles++;
      if (!busy) break;
      step();
    end
    chk("stall_cycles", 64'(stall_cycles), 64'd32);
    mf_req = 0;
    chk("divu", {hi_reg, lo_reg}, {32'd1, 32'd333});

    send(3'd2, 32'd5, 32'd5);
    repeat (9) step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hilo", {hi_reg, lo_reg}, {32'd1, 32'd333});
    repeat (3) step();
    send(3'd2, 32'd5, 32'd5);
    wait_idle();
    chk("multu_after_flush", {hi_reg, lo_reg}, 64'd25);

    send(3'd1, 32'h00001234, 32'h00005678);
    repeat (19) step();
    rst = 1;
    #1;
    chk("async_rst_lo", {32'd0, lo_reg}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    step();
    rst = 0;
    send(3'd1, 32'd2, 32'd3);
    wait_idle();
    chk("mult_after_rst", {hi_reg, lo_reg}, 64'd6);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage; owns the architectural HI and LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives hi_reg/lo_reg straight into the register file, which consumes them for MFHI/MFLO.
- Raises stall so the hazard logic freezes the front of the pipeline while a result is pending.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER, 32, busy cycles per mult/div op; must equal XLEN (one bit per cycle).

Ports:
- clk  in  1  pipeline clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  decoded muldiv/mthi/mtlo instruction present in EX this cycle
- op  in  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0 and 7 are no-ops
- rs_data  in  XLEN  forwarded rs value (multiplicand / dividend / mt source)
- rt_data  in  XLEN  forwarded rt value (multiplier / divisor)
- mf_req  in  1  MFHI or MFLO in decode this cycle
- flush  in  1  squash the in-flight op (branch/exception)
- hi_reg  out  XLEN  architectural HI
- lo_reg  out  XLEN  architectural LO
- busy  out  1  iterative op in flight
- stall  out  1  stall request to hazard unit
- done  out  1  one-cycle pulse when HI/LO take a mult/div result

Behaviour:
- Reset (async, any time, including mid-op):
  - hi_reg=0, lo_reg=0, busy=0, done=0.
  - Counter and internal accumulators cleared; the op in flight is discarded.
- Acceptance: an op is accepted on a posedge when op_valid=1, op in 1..6, busy=0 and flush=0.
- MTHI / MTLO, busy=0:
  - hi_reg (resp. lo_reg) <= rs_data at that edge; one-cycle latency.
  - busy stays 0 and done is not pulsed.
- MULT/MULTU/DIV/DIVU, states IDLE -> RUN -> IDLE:
  - Acceptance edge E0: latch operands and op type, counter=0, busy=1.
  - Signed ops latch magnitudes plus the result sign flags.
- RUN, one iteration per edge:
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring; one quotient bit and partial remainder per edge.
- Completion on edge E_ITER (32nd RUN edge):
  - hi_reg/lo_reg written in the same edge; done=1 for the following cycle only; busy=0.
  - The unit can accept a new op at E_ITER+1.
  - Total latency: 32 cycles from acceptance to result visible on hi_reg/lo_reg.
- Result definitions:
  - Multiply: {hi,lo} = full 64-bit product. MULT is two's-complement; MULTU is unsigned.
  - Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Divide by zero: no trap; still takes 32 cycles; lo=32'hFFFFFFFF, hi=rs_data, for both DIV and DIVU.
- DIV overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0.
- HI/LO while busy: hold their pre-op values until the completion edge. No partial results are exposed.
- Stall: stall = busy & (mf_req | (op_valid & op in 1..6)). It is combinational. Ops arriving while busy are not accepted; the pipeline must hold and re-present them.
- Flush:
  - With busy=1: the next edge returns to IDLE, busy=0, no done, HI/LO unchanged.
  - With busy=0: blocks acceptance on that edge.
  - Flush has priority over completion on the same edge: the result is discarded.
- Independent ops on the same edge: an mt* op accepted on the edge a mult/div completes is impossible, since busy=1 blocks it. No write-ordering conflict can arise.
- Ops 0/7 with op_valid=1: ignored; no stall.

Test Plan:
- Reset, then MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 -> hi_reg=0x12345678 one cycle after the first edge, lo_reg=0x9ABCDEF0 one cycle later; busy never set.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy for 32 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB. The same operands with MULTU -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mf_req held during DIVU 1000/3 -> stall=1 for exactly the 32 busy cycles, deasserts with done; then hi=1, lo=333.
- MULTU 5*5 with flush at RUN cycle 10 -> busy drops next edge, no done, HI/LO keep prior values. A fresh MULTU 5*5 afterwards gives lo=25, hi=0.
- Assert rst at RUN cycle 20 of a MULT -> all outputs 0 immediately (async); after release, a new MULT 2*3 completes with lo=6.
